crossbar_one_hot_cmd_gen: RTL and testbench
===========================================

// Module: crossbar_one_hot_cmd_gen
// PURPOSE
//  Initiator for the one-hot crossbar command interface. Accepts per-input routing requests
//  (valid/ready, binary destination) and arbitrates each output round-robin. Emits the registered
//  NUM_INPUT_DATA*NUM_OUTPUT_DATA one-hot command and enable that the 3-stage crossbar consumes.
//  Tracks in-flight grants so a scoreboard knows when each crossbar output must present valid.
// PARAMETERS
//  NUM_INPUT_DATA   32  crossbar inputs (requesters)
//  NUM_OUTPUT_DATA  8   crossbar outputs; power of 2
//  XBAR_LATENCY     3   cycles from o_cmd sampled by the crossbar to its o_valid; >=1
// PORTS
//  clk            in   1                      single clock, rising edge
//  rst            in   1                      asynchronous, active-low reset
//  i_en           in   1                      global enable
//  i_req_valid    in   NUM_INPUT_DATA         input k has a transfer pending
//  i_req_dest     in   NUM_INPUT_DATA*DEST_W  dest of input k at [k*DEST_W+:DEST_W]; DEST_W=clog2(NUM_OUTPUT_DATA)
//  o_req_ready    out  NUM_INPUT_DATA         combinational grant; transfer on valid&ready at edge
//  i_out_ready    in   NUM_OUTPUT_DATA        output j may accept a new route this cycle
//  o_cmd          out  NUM_INPUT_DATA*NUM_OUTPUT_DATA  one-hot command; bit k*NUM_OUTPUT_DATA+j = in k -> out j
//  o_en           out  1                      registered copy of i_en; drives crossbar enable
//  o_expect_valid out  NUM_OUTPUT_DATA        crossbar output j must show valid this cycle
// BEHAVIOUR
//  - Reset (rst=0, async): o_cmd=0, o_en=0, o_expect_valid=0, all RR pointers=0.
//    o_req_ready is forced 0 while rst=0. A reset mid-operation discards in-flight expectations.
//  - Request k targets column j=i_req_dest[k]. Input k and its dest are held stable until handshake.
//  - Per output j, in cycle t: candidates = {k : i_req_valid[k] && dest[k]==j}. Arbitrate only if
//    i_en && i_out_ready[j]. Priority is round-robin starting at ptr[j] and wrapping NUM_INPUT_DATA-1 -> 0.
//  - Grant to k: o_req_ready[k]=1 in cycle t (combinational); at edge t+1, o_cmd bit (k,j)=1 and
//    ptr[j]=(k+1) mod NUM_INPUT_DATA. No grant: ptr[j] holds and column j of o_cmd is 0.
//  - Each input names one dest, so each o_cmd row has <=1 bit set and each column has <=1 bit set,
//    every cycle. o_cmd is cleared each cycle unless re-granted (single-cycle pulse per transfer).
//  - Requester k drives its data and i_valid into the crossbar in cycle t+1, aligned with o_cmd.
//  - o_en <= i_en each edge. With i_en=0: no grants, o_cmd=0 next cycle, pointers hold.
//    Expect pipe keeps shifting, so in-flight results still appear only if the crossbar is enabled.
//  - o_expect_valid[j] = OR over column j of o_cmd, delayed XBAR_LATENCY cycles by a shift register.
//    The delay resets to 0. Back-to-back grants to one output yield back-to-back expect pulses.
//  - Simultaneous: all NUM_INPUT_DATA inputs -> same j: one grant per cycle, k order from ptr[j],
//    starvation-free (max wait NUM_INPUT_DATA-1 grants). Distinct dests: up to NUM_OUTPUT_DATA grants/cycle.
//  - i_req_valid dropped without handshake is illegal (assertion); the block does not retain
//    withdrawn requests.
// STRUCTURE
//  - Package crossbar_pkg: DEST_W, CMD_W=NUM_INPUT_DATA*NUM_OUTPUT_DATA, function cmd_idx(k,j)=k*NUM_OUTPUT_DATA+j,
//    default XBAR_LATENCY.
//  - Sub-module xbar_rr_arbiter (NUM_INPUT_DATA-wide req -> one-hot grant, pointer reg, async
//    active-low reset). Instantiated NUM_OUTPUT_DATA times. The top ORs grants per input into
//    o_req_ready and registers o_cmd and the expect pipe.
// TESTING
//  1 Reset: rst=0 with i_req_valid=all-1 -> o_cmd=0, o_en=0, o_req_ready=0, o_expect_valid=0.
//  2 Single route: i_en=1, in5 dest=2 -> o_req_ready[5]=1 same cycle; next cycle o_cmd bit 42 only;
//    o_expect_valid=8'h04 exactly 3 cycles later.
//  3 Contention: in0,in7,in31 all dest=6, held -> grants in0,in7,in31 on consecutive cycles, then
//    in0 again; ptr[6] wraps 0 after in31.
//  4 Parallel: in k dest=k%8 for k=0..7 -> all 8 ready in one cycle; o_cmd has 8 bits, one per
//    column; o_expect_valid=8'hFF 3 cycles later.
//  5 Back-pressure/enable: i_out_ready[3]=0 with in9 dest=3 -> no grant, ptr holds. Raising it
//    grants in9. i_en=0 -> o_en=0 next cycle, o_cmd=0.
//  6 Mid-op reset: grant issued, rst pulsed low 1 cycle later -> o_expect_valid never asserts for it;
//    ptrs back to 0.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared constants and helpers for the one-hot crossbar command generator.
// Defaults match the reference crossbar build; the top re-derives widths from its own parameters.
package crossbar_pkg;

  localparam int unsigned NUM_INPUT_DATA_DEF  = 32;
  localparam int unsigned NUM_OUTPUT_DATA_DEF = 8;
  localparam int unsigned XBAR_LATENCY_DEF    = 3;
  localparam int unsigned DEST_W              = $clog2(NUM_OUTPUT_DATA_DEF);
  localparam int unsigned CMD_W               = NUM_INPUT_DATA_DEF * NUM_OUTPUT_DATA_DEF;

  // Bit position of route (input k -> output j) inside the flattened command word.
  function automatic int unsigned cmd_idx(input int unsigned k, input int unsigned j,
                                          input int unsigned n_out = NUM_OUTPUT_DATA_DEF);
    return k * n_out + j;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr_q, pointer moves past the winner.
module xbar_rr_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  sel;
  logic [N-1:0]  first;

  // Requests at or above the pointer win first; otherwise wrap to the lowest request.
  always_comb begin
    hi_req = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_req[i] = req_i[i] && (PW'(i) >= ptr_q);
    end
    sel   = (|hi_req) ? hi_req : req_i;
    first = sel & (~sel + N'(1));
    gnt_o = en_i ? first : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_o[i]) begin
        ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/crossbar_one_hot_cmd_gen.sv
// Command initiator for the one-hot crossbar: per-output round-robin arbitration of routing
// requests, registered one-hot command/enable, and a latency-matched expected-valid pipe.
module crossbar_one_hot_cmd_gen
  import crossbar_pkg::*;
#(
  parameter int unsigned NUM_INPUT_DATA  = NUM_INPUT_DATA_DEF,
  parameter int unsigned NUM_OUTPUT_DATA = NUM_OUTPUT_DATA_DEF,
  parameter int unsigned XBAR_LATENCY    = XBAR_LATENCY_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_en,
  input  logic [NUM_INPUT_DATA-1:0]                 i_req_valid,
  input  logic [NUM_INPUT_DATA*$clog2(NUM_OUTPUT_DATA)-1:0] i_req_dest,
  output logic [NUM_INPUT_DATA-1:0]                 o_req_ready,
  input  logic [NUM_OUTPUT_DATA-1:0]                i_out_ready,
  output logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd,
  output logic                                      o_en,
  output logic [NUM_OUTPUT_DATA-1:0]                o_expect_valid
);

  localparam int unsigned DW = $clog2(NUM_OUTPUT_DATA);
  localparam int unsigned CW = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

  logic [NUM_INPUT_DATA-1:0]  col_req [NUM_OUTPUT_DATA];
  logic [NUM_INPUT_DATA-1:0]  col_gnt [NUM_OUTPUT_DATA];
  logic [CW-1:0]              cmd_d, cmd_q;
  logic                       en_q;
  logic [NUM_OUTPUT_DATA-1:0] col_busy;
  logic [NUM_OUTPUT_DATA-1:0] exp_q [XBAR_LATENCY];

  always_comb begin
    for (int unsigned j = 0; j < NUM_OUTPUT_DATA; j++) begin
      col_req[j] = '0;
      for (int unsigned k = 0; k < NUM_INPUT_DATA; k++) begin
        col_req[j][k] = i_req_valid[k] && (i_req_dest[k*DW +: DW] == DW'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_OUTPUT_DATA; j++) begin : g_arb
    xbar_rr_arbiter #(
      .N (NUM_INPUT_DATA)
    ) u_arb (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (i_en & i_out_ready[j]),
      .req_i  (col_req[j]),
      .gnt_o  (col_gnt[j])
    );
  end

  // An input names one destination, so at most one column can grant it per cycle.
  always_comb begin
    o_req_ready = '0;
    cmd_d       = '0;
    for (int unsigned j = 0; j < NUM_OUTPUT_DATA; j++) begin
      for (int unsigned k = 0; k < NUM_INPUT_DATA; k++) begin
        if (col_gnt[j][k]) begin
          o_req_ready[k]                           = 1'b1;
          cmd_d[cmd_idx(k, j, NUM_OUTPUT_DATA)]    = 1'b1;
        end
      end
    end
    if (!rst) begin
      o_req_ready = '0;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_OUTPUT_DATA; j++) begin
      col_busy[j] = 1'b0;
      for (int unsigned k = 0; k < NUM_INPUT_DATA; k++) begin
        col_busy[j] = col_busy[j] | cmd_q[cmd_idx(k, j, NUM_OUTPUT_DATA)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= '0;
      en_q  <= 1'b0;
      for (int unsigned i = 0; i < XBAR_LATENCY; i++) begin
        exp_q[i] <= '0;
      end
    end else begin
      cmd_q    <= cmd_d;
      en_q     <= i_en;
      exp_q[0] <= col_busy;
      for (int unsigned i = 1; i < XBAR_LATENCY; i++) begin
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  assign o_cmd          = cmd_q;
  assign o_en           = en_q;
  assign o_expect_valid = exp_q[XBAR_LATENCY-1];

  // A pending request must stay asserted until it is granted.
  for (genvar k = 0; k < NUM_INPUT_DATA; k++) begin : g_hold_chk
    a_req_hold: assert property (@(posedge clk) disable iff (!rst)
      (i_req_valid[k] && !o_req_ready[k]) |=> i_req_valid[k]);
  end

endmodule

// File: tb/tb_crossbar_one_hot_cmd_gen.sv
// Scoreboard bench for crossbar_one_hot_cmd_gen: a round-robin reference model queues expected
// grants, commands, enables and latency-delayed expect-valids, compared as the DUT produces them.
module tb_crossbar_one_hot_cmd_gen;

  localparam int NI = 32;
  localparam int NO = 8;
  localparam int DW = 3;
  localparam int L  = 3;
  localparam int CW = NI * NO;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_en = 1'b0;
  logic [NI-1:0]     i_req_valid = '0;
  logic [NI*DW-1:0]  i_req_dest = '0;
  logic [NI-1:0]     o_req_ready;
  logic [NO-1:0]     i_out_ready = '0;
  logic [CW-1:0]     o_cmd;
  logic              o_en;
  logic [NO-1:0]     o_expect_valid;

  crossbar_one_hot_cmd_gen #(
    .NUM_INPUT_DATA  (NI),
    .NUM_OUTPUT_DATA (NO),
    .XBAR_LATENCY    (L)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (i_en),
    .i_req_valid    (i_req_valid),
    .i_req_dest     (i_req_dest),
    .o_req_ready    (o_req_ready),
    .i_out_ready    (i_out_ready),
    .o_cmd          (o_cmd),
    .o_en           (o_en),
    .o_expect_valid (o_expect_valid)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  int            ptr_m [NO];
  int            left  [NI];
  int            dst   [NI];
  logic [CW-1:0] cmd_q [$];
  logic          en_q  [$];
  logic [NO-1:0] exv_q [$];

  logic [NI-1:0] last_rdy;
  logic [CW-1:0] last_cmd;
  logic [NO-1:0] last_exv;
  logic          last_en;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int j = 0; j < NO; j++) ptr_m[j] = 0;
    for (int k = 0; k < NI; k++) left[k] = 0;
    cmd_q.delete();
    en_q.delete();
    exv_q.delete();
    for (int i = 0; i < L; i++) exv_q.push_back('0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    logic [NI-1:0] eg;
    logic [CW-1:0] ec;
    logic [NO-1:0] col;
    logic [NI-1:0] r;
    logic          got;
    int            k;
    for (int n = 0; n < NI; n++) begin
      i_req_valid[n]          = (left[n] > 0);
      i_req_dest[n*DW +: DW]  = 3'(dst[n]);
    end
    #1;
    eg  = '0;
    ec  = '0;
    col = '0;
    for (int j = 0; j < NO; j++) begin
      if (i_en && i_out_ready[j]) begin
        got = 1'b0;
        for (int i = 0; i < NI; i++) begin
          k = (ptr_m[j] + i) % NI;
          if (!got && i_req_valid[k] && dst[k] == j) begin
            got          = 1'b1;
            eg[k]        = 1'b1;
            ec[k*NO + j] = 1'b1;
            col[j]       = 1'b1;
            ptr_m[j]     = (k + 1) % NI;
          end
        end
      end
    end
    r        = o_req_ready;
    last_rdy = r;
    check_eq("ready", r, eg);
    cmd_q.push_back(ec);
    en_q.push_back(i_en);
    exv_q.push_back(col);
    @(posedge clk);
    #1;
    last_cmd = o_cmd;
    last_en  = o_en;
    last_exv = o_expect_valid;
    check_eq("cmd", o_cmd, cmd_q.pop_front());
    check_eq("en", o_en, en_q.pop_front());
    check_eq("expect", o_expect_valid, exv_q.pop_front());
    for (int n = 0; n < NI; n++) begin
      if (i_req_valid[n] && r[n]) left[n]--;
    end
    @(negedge clk);
  endtask

  logic [CW-1:0] v;

  initial begin
    for (int k = 0; k < NI; k++) dst[k] = 0;
    // Reset with every input requesting.
    rst         = 1'b0;
    i_en        = 1'b1;
    i_out_ready = '1;
    i_req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cmd", o_cmd, '0);
    check_eq("rst_en", o_en, '0);
    check_eq("rst_ready", o_req_ready, '0);
    check_eq("rst_expect", o_expect_valid, '0);
    @(negedge clk);
    reset_model();
    i_req_valid = '0;
    rst = 1'b1;
    step();

    // Single route in5 -> out2.
    left[5] = 1; dst[5] = 2;
    step();
    check_eq("t2_ready", last_rdy, 32'h20);
    v = '0; v[42] = 1'b1;
    check_eq("t2_cmd", last_cmd, v);
    step(); step();
    check_eq("t2_expect_early", last_exv, 8'h00);
    step();
    check_eq("t2_expect", last_exv, 8'h04);

    // Contention on out6 with wrap.
    left[0] = 2; dst[0] = 6;
    left[7] = 1; dst[7] = 6;
    left[31] = 1; dst[31] = 6;
    step(); check_eq("t3_g0", last_rdy, 32'h0000_0001);
    step(); check_eq("t3_g1", last_rdy, 32'h0000_0080);
    step(); check_eq("t3_g2", last_rdy, 32'h8000_0000);
    step(); check_eq("t3_g3", last_rdy, 32'h0000_0001);
    repeat (2) step();

    // Parallel routes k -> k.
    for (int k = 0; k < NO; k++) begin
      left[k] = 1; dst[k] = k;
    end
    step();
    check_eq("t4_ready", last_rdy, 32'hFF);
    v = '0;
    for (int k = 0; k < NO; k++) v[k*NO + k] = 1'b1;
    check_eq("t4_cmd", last_cmd, v);
    repeat (3) step();
    check_eq("t4_expect", last_exv, 8'hFF);

    // Back-pressure on out3, then global disable.
    i_out_ready[3] = 1'b0;
    left[9] = 1; dst[9] = 3;
    step(); check_eq("t5_bp_ready", last_rdy, '0);
    step(); check_eq("t5_bp_cmd", last_cmd, '0);
    i_out_ready[3] = 1'b1;
    step(); check_eq("t5_release", last_rdy, 32'h200);
    i_en = 1'b0;
    left[1] = 1; dst[1] = 0;
    step();
    check_eq("t5_dis_ready", last_rdy, '0);
    check_eq("t5_dis_en", last_en, 1'b0);
    check_eq("t5_dis_cmd", last_cmd, '0);
    i_en = 1'b1;
    step(); check_eq("t5_reen", last_rdy, 32'h2);
    repeat (3) step();

    // Mid-operation reset discards the in-flight expectation and pointers.
    left[10] = 1; dst[10] = 6;
    step();
    left[4] = 1; dst[4] = 1;
    step();
    v = '0; v[4*NO + 1] = 1'b1;
    check_eq("t6_cmd", last_cmd, v);
    rst = 1'b0;
    #1;
    check_eq("t6_async_cmd", o_cmd, '0);
    check_eq("t6_async_expect", o_expect_valid, '0);
    @(posedge clk);
    @(negedge clk);
    reset_model();
    rst = 1'b1;
    left[0] = 1; dst[0] = 6;
    left[20] = 1; dst[20] = 6;
    step(); check_eq("t6_ptr_reset", last_rdy, 32'h1);
    step(); check_eq("t6_next", last_rdy, 32'h0010_0000);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
